// File: rtl/zigzag_pkg.sv
// -----------------------------------------------------------------------------
// zigzag_pkg
// Shared constants for the zig-zag block streamer:
//   BLK_SIZE / IDX_W : coefficients per 8x8 block and coefficient index width
//   MODE_ZIGZAG / MODE_RASTER : readout order encodings
//   ZZ_ORDER  : JPEG zig-zag index -> raster position table
//   order_idx : maps (mode, stream index) to the raster address to read
// -----------------------------------------------------------------------------
package zigzag_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;

  localparam logic MODE_ZIGZAG = 1'b0;
  localparam logic MODE_RASTER = 1'b1;

  localparam logic [IDX_W-1:0] ZZ_ORDER [0:BLK_SIZE-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Raster address of stream position idx for the given readout order.
  function automatic logic [IDX_W-1:0] order_idx(input logic mode,
                                                 input logic [IDX_W-1:0] idx);
    if (mode == MODE_ZIGZAG) begin
      return ZZ_ORDER[idx];
    end else begin
      return idx;
    end
  endfunction

endpackage : zigzag_pkg

// File: rtl/zz_bank.sv
// -----------------------------------------------------------------------------
// zz_bank
// One 8x8 coefficient block store: parallel load of a whole block, indexed
// single-coefficient read.
//   clk, rst   : clock, asynchronous active-low reset (clears contents)
//   ena        : clock enable
//   load       : capture din on this edge (qualified by ena)
//   din        : flat block, element k at [k*DWIDTH +: DWIDTH]
//   raddr      : raster address of the coefficient to read
//   rdata      : coefficient at raddr (combinational read)
// -----------------------------------------------------------------------------
module zz_bank
  import zigzag_pkg::*;
#(
  parameter int DWIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       load,
  input  logic [BLK_SIZE*DWIDTH-1:0] din,
  input  logic [IDX_W-1:0]           raddr,
  output logic [DWIDTH-1:0]          rdata
);

  logic [DWIDTH-1:0] mem_r [0:BLK_SIZE-1];

  // Block storage: cleared on reset so no stale coefficient survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BLK_SIZE; i++) begin
        mem_r[i] <= '0;
      end
    end else if (ena && load) begin
      for (int i = 0; i < BLK_SIZE; i++) begin
        mem_r[i] <= din[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule : zz_bank

// File: rtl/zigzag_stream.sv
// -----------------------------------------------------------------------------
// zigzag_stream
// Accepts a full 8x8 block on a parallel bus into a ping-pong pair of banks
// and streams it out one coefficient per cycle in zig-zag or raster order.
//   clk, rst     : clock, asynchronous active-low reset
//   ena          : clock enable; all state holds while low
//   din          : block, element r*8+c at [(r*8+c)*DWIDTH +: DWIDTH]
//   din_valid    : block present on din
//   din_ready    : a bank is free (combinational from the full flags)
//   mode_sel_en  : take readout order from mode instead of DEF_MODE
//   mode         : readout order for the block being accepted
//   dout         : registered output coefficient
//   dout_valid   : dout holds a coefficient
//   dout_ready   : downstream takes dout
//   dout_sob     : dout is coefficient 0 of its block
//   dout_eob     : dout is coefficient 63 of its block
// -----------------------------------------------------------------------------
module zigzag_stream
  import zigzag_pkg::*;
#(
  parameter int   DWIDTH   = 12,
  parameter logic DEF_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [BLK_SIZE*DWIDTH-1:0] din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       mode_sel_en,
  input  logic                       mode,
  output logic [DWIDTH-1:0]          dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_sob,
  output logic                       dout_eob
);

  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        full_r;
  logic [1:0]        mode_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DWIDTH-1:0] dout_r;
  logic              dout_valid_r;
  logic              dout_sob_r;
  logic              dout_eob_r;

  logic              accept_s;
  logic              load_s;
  logic              last_s;
  logic              new_mode_s;
  logic [1:0]        bank_load_s;
  logic [IDX_W-1:0]  raddr_s;
  logic [DWIDTH-1:0] bank_rdata_s [0:1];
  logic [DWIDTH-1:0] rdata_s;

  // The write bank is never the full bank being drained, so accept and
  // drain always target different banks.
  assign din_ready  = rst & ~full_r[wr_ptr_r];
  assign accept_s   = ena & din_valid & din_ready;
  assign load_s     = ena & full_r[rd_ptr_r] & (~dout_valid_r | dout_ready);
  assign last_s     = (idx_r == 6'd63);
  assign new_mode_s = mode_sel_en ? mode : DEF_MODE;
  assign raddr_s    = order_idx(mode_r[rd_ptr_r], idx_r);
  assign rdata_s    = rd_ptr_r ? bank_rdata_s[1] : bank_rdata_s[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_load_s[b] = accept_s & (wr_ptr_r == b[0]);

    zz_bank #(
      .DWIDTH (DWIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .load  (bank_load_s[b]),
      .din   (din),
      .raddr (raddr_s),
      .rdata (bank_rdata_s[b])
    );
  end

  // Bank bookkeeping: write/read pointers, full flags, per-bank mode, index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      full_r   <= 2'b00;
      mode_r   <= 2'b00;
      idx_r    <= 6'd0;
    end else begin
      if (accept_s) begin
        full_r[wr_ptr_r] <= 1'b1;
        mode_r[wr_ptr_r] <= new_mode_s;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (load_s) begin
        if (last_s) begin
          full_r[rd_ptr_r] <= 1'b0;
          rd_ptr_r         <= ~rd_ptr_r;
          idx_r            <= 6'd0;
        end else begin
          idx_r <= idx_r + 6'd1;
        end
      end
    end
  end

  // Output register: loads the next coefficient or empties when drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_sob_r   <= 1'b0;
      dout_eob_r   <= 1'b0;
    end else if (load_s) begin
      dout_r       <= rdata_s;
      dout_valid_r <= 1'b1;
      dout_sob_r   <= (idx_r == 6'd0);
      dout_eob_r   <= last_s;
    end else if (ena && dout_ready) begin
      dout_valid_r <= 1'b0;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_sob   = dout_sob_r;
  assign dout_eob   = dout_eob_r;

endmodule : zigzag_stream

// File: tb/tb_zigzag_stream.sv
module tb_zigzag_stream;

  localparam int DW = 12;

  localparam int ZZ_TB [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    logic sel;
    logic md;
    int   base;
  } blk_t;

  typedef struct {
    int idx;
    int exp;
  } spot_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          sob;
    logic          eob;
    int            cyc;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic [64*DW-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic            mode_sel_en;
  logic            mode;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_sob;
  logic            dout_eob;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  ent_t q[$];

  zigzag_stream #(.DWIDTH(DW), .DEF_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .mode_sel_en(mode_sel_en), .mode(mode),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sob(dout_sob), .dout_eob(dout_eob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record each coefficient that will be handed over on the coming edge.
  always @(negedge clk) begin
    if (rst && ena && dout_valid && dout_ready) begin
      ent_t e;
      e.d = dout; e.sob = dout_sob; e.eob = dout_eob; e.cyc = cyc;
      q.push_back(e);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_val(logic sel, logic md, int base, int idx);
    int pos;
    pos = (sel && md) ? idx : ZZ_TB[idx];
    return (base + pos) % 4096;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic sel, input logic md, input int base,
                            output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 64; i++) din[i*DW +: DW] = DW'((base + i) % 4096);
    mode_sel_en = sel;
    mode = md;
    din_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (din_ready) begin
        tick();
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
      tick();
    end
    din_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_q(input int n);
    for (int t = 0; t < 600 && q.size() < n; t++) tick();
    if (q.size() < n) chk("stream_timeout", q.size(), n);
  endtask

  task automatic wait_val(input int v);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (dout_valid && dout == DW'(v)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_value_timeout", 0, v);
  endtask

  task automatic check_block(input int off, input logic sel, input logic md,
                             input int base, input string tag);
    for (int i = 0; i < 64; i++) begin
      int e;
      e = exp_val(sel, md, base, i);
      n_chk++;
      if (off + i >= q.size()) begin
        $display("FAIL %s[%0d]: got no coefficient, expected d=%0d", tag, i, e);
      end else if (q[off+i].d == DW'(e) && q[off+i].sob == (i == 0) &&
                   q[off+i].eob == (i == 63)) begin
        n_pass++;
      end else begin
        $display("FAIL %s[%0d]: got d=%0d sob=%0b eob=%0b, expected d=%0d sob=%0b eob=%0b",
                 tag, i, q[off+i].d, q[off+i].sob, q[off+i].eob, e, i == 0, i == 63);
      end
    end
  endtask

  initial begin
    blk_t  blocks [4];
    spot_t spots  [8];
    int    acc_a, acc_b, acc_c, nvalid;
    bit    gap;

    blocks[0] = '{sel: 1'b0, md: 1'b0, base: 0};
    blocks[1] = '{sel: 1'b1, md: 1'b1, base: 0};
    blocks[2] = '{sel: 1'b1, md: 1'b0, base: 100};
    blocks[3] = '{sel: 1'b0, md: 1'b1, base: 200};
    spots = '{'{0, 0}, '{2, 8}, '{3, 16}, '{10, 32}, '{11, 25},
              '{20, 40}, '{35, 56}, '{63, 63}};

    rst = 1'b0; ena = 1'b1; din = '0; din_valid = 1'b0;
    mode_sel_en = 1'b0; mode = 1'b0; dout_ready = 1'b1;

    // reset state
    #1;
    chk("reset_din_ready", din_ready, 0);
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_sob_eob", {dout_sob, dout_eob}, 0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("release_din_ready", din_ready, 1);
    tick();

    // latency: coefficient 0 registered one edge after accept
    q.delete();
    send_block(1'b0, 1'b0, 0, acc_a);
    chk("lat_not_yet_valid", dout_valid, 0);
    tick();
    chk("lat_valid", dout_valid, 1);
    chk("lat_first", {dout, dout_sob}, {12'd0, 1'b1});
    wait_q(64);
    for (int i = 0; i < 8; i++) chk($sformatf("spot_idx%0d", spots[i].idx),
                                    (spots[i].idx < q.size()) ? int'(q[spots[i].idx].d) : -1,
                                    spots[i].exp);
    repeat (2) tick();

    // table-driven single blocks
    for (int b = 0; b < 4; b++) begin
      q.delete();
      send_block(blocks[b].sel, blocks[b].md, blocks[b].base, acc_a);
      wait_q(64);
      check_block(0, blocks[b].sel, blocks[b].md, blocks[b].base, $sformatf("blk%0d", b));
      repeat (2) tick();
    end
    chk("idle_valid", dout_valid, 0);

    // three blocks back to back, gapless
    q.delete();
    send_block(1'b0, 1'b0, 300, acc_a);
    send_block(1'b1, 1'b1, 500, acc_b);
    chk("both_full_din_ready", din_ready, 0);
    send_block(1'b1, 1'b0, 700, acc_c);
    wait_q(192);
    chk("third_accept_cycle", acc_c, (q.size() > 63) ? q[63].cyc + 1 : -1);
    gap = 1'b0;
    for (int i = 1; i < q.size(); i++) if (q[i].cyc != q[i-1].cyc + 1) gap = 1'b1;
    chk("gapless_192", gap, 0);
    check_block(0, 1'b0, 1'b0, 300, "b2b_a");
    check_block(64, 1'b1, 1'b1, 500, "b2b_b");
    check_block(128, 1'b1, 1'b0, 700, "b2b_c");
    repeat (2) tick();

    // backpressure stall at idx 10
    q.delete();
    send_block(1'b0, 1'b0, 0, acc_a);
    wait_val(32);
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), {dout_valid, dout}, {1'b1, 12'd32});
    end
    dout_ready = 1'b1;
    tick();
    chk("stall_resume", dout, 25);
    wait_q(64);
    check_block(0, 1'b0, 1'b0, 0, "stall");
    repeat (2) tick();

    // clock-enable freeze at idx 15
    q.delete();
    send_block(1'b0, 1'b0, 0, acc_a);
    wait_val(5);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("freeze_hold%0d", k), {dout_valid, dout_sob, dout_eob, dout},
          {1'b1, 1'b0, 1'b0, 12'd5});
    end
    ena = 1'b1;
    tick();
    chk("freeze_resume", dout, 12);
    wait_q(64);
    check_block(0, 1'b0, 1'b0, 0, "freeze");
    repeat (2) tick();

    // reset mid-block with second bank full
    q.delete();
    send_block(1'b0, 1'b0, 0, acc_a);
    send_block(1'b0, 1'b0, 1000, acc_b);
    chk("pre_reset_din_ready", din_ready, 0);
    wait_val(21);
    rst = 1'b0;
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout", dout, 0);
    tick();
    chk("rst_hold_din_ready", din_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_release_din_ready", din_ready, 1);
    q.delete();
    nvalid = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (dout_valid) nvalid++;
    end
    chk("no_stale_valid", nvalid, 0);
    chk("no_stale_data", q.size(), 0);

    // fresh block after reset
    send_block(1'b1, 1'b1, 2000, acc_a);
    wait_q(64);
    check_block(0, 1'b1, 1'b1, 2000, "post_rst");
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_zigzag_stream
